// File: rtl/pc_sequencer.sv
// Fetch/sequencing controller driving a loadable PC counter: fetches at pc,
// latches the instruction, then applies halt/stall/jump/sequential in DECODE.
module pc_sequencer #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  jump_valid,
  input  logic [WIDTH-1:0]      jump_target,
  input  logic [WIDTH-1:0]      pc,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_req,
  output logic                  pc_enable,
  output logic                  pc_count,
  output logic                  pc_load,
  output logic [WIDTH-1:0]      pc_load_value,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  running,
  output logic                  halted,
  output logic                  wrap
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALTED} state_t;

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      instr <= '0;
    end else begin
      case (state)
        IDLE:   if (start) state <= FETCH;
        FETCH:  if (mem_ready) begin
                  instr <= mem_data;
                  state <= DECODE;
                end
        DECODE: if (halt)        state <= HALTED;
                else if (!stall) state <= FETCH;
        HALTED: if (start) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req     = (state == FETCH);
  assign instr_valid = (state == DECODE);
  assign running     = (state == FETCH) || (state == DECODE);
  assign halted      = (state == HALTED);

  // Gated by reset so the counter sees no advance request in a reset cycle.
  logic advance;
  assign advance = !reset && (state == DECODE) && !halt && !stall;

  always_comb begin
    pc_enable     = advance;
    pc_load       = advance && jump_valid;
    pc_count      = advance && !jump_valid;
    pc_load_value = '0;
    if (pc_load) pc_load_value = jump_target;
    wrap          = pc_count && (&pc);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a PC counter and instruction memory around the DUT,
// a cycle-level reference model, directed plan scenarios and random traffic.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, halt, stall, jump_valid, mem_ready;
  logic [7:0]  jump_target, pc, pc_load_value;
  logic [15:0] mem_data, instr;
  logic        mem_req, pc_enable, pc_count, pc_load, instr_valid, running, halted, wrap;

  logic [15:0] mem [256];
  int checks = 0;
  int passes = 0;

  // Reference model: phase 0 idle, 1 fetching, 2 decoding, 3 halted.
  int          ph;
  logic [7:0]  mpc;
  logic [15:0] minstr;

  always #5 clock = ~clock;

  pc_sequencer #(.WIDTH(8), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .jump_valid(jump_valid), .jump_target(jump_target), .pc(pc),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_req(mem_req),
    .pc_enable(pc_enable), .pc_count(pc_count), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .instr(instr), .instr_valid(instr_valid),
    .running(running), .halted(halted), .wrap(wrap)
  );

  // PC counter environment: count has priority over load.
  always_ff @(posedge clock) begin
    if (reset) pc <= '0;
    else if (pc_enable) begin
      if (pc_count)     pc <= pc + 8'd1;
      else if (pc_load) pc <= pc_load_value;
    end
  end

  assign mem_data = mem[pc];

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Apply inputs, then compare every output against the model.
  task automatic drive(input logic r, s, h, st, j, input logic [7:0] jt, input logic rdy);
    logic en, ld, cnt, wr;
    logic [7:0] lv;
    logic [39:0] got, exp;
    reset = r; start = s; halt = h; stall = st; jump_valid = j;
    jump_target = jt; mem_ready = rdy;
    #1;
    en  = !r && ph == 2 && !h && !st;
    ld  = en && j;
    cnt = en && !j;
    lv  = ld ? jt : 8'h00;
    wr  = cnt && mpc == 8'hFF;
    exp = {ph == 1, en, cnt, ld, ph == 2, ph == 1 || ph == 2, ph == 3, wr, lv, minstr, mpc};
    got = {mem_req, pc_enable, pc_count, pc_load, instr_valid, running, halted, wrap,
           pc_load_value, instr, pc};
    chk("model", got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      ph = 0; mpc = 8'h00; minstr = 16'h0000;
    end else begin
      case (ph)
        0: if (start) ph = 1;
        1: if (mem_ready) begin minstr = mem[mpc]; ph = 2; end
        2: if (halt) ph = 3;
           else if (!stall) begin
             mpc = jump_valid ? jump_target : mpc + 8'd1;
             ph = 1;
           end
        default: if (start) ph = 1;
      endcase
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[3] = 16'hBEEF;
    reset = 1'b1; start = 0; halt = 0; stall = 0; jump_valid = 0;
    jump_target = 8'h00; mem_ready = 0;
    @(posedge clock); @(negedge clock);
    ph = 0; mpc = 8'h00; minstr = 16'h0000;

    drive(1, 0, 0, 0, 0, 8'h00, 0);
    chk("reset_outs", {mem_req, pc_enable, instr_valid, running, halted, wrap, instr, pc},
        40'h0);
    tick();
    drive(0, 1, 0, 0, 0, 8'h00, 0); tick();

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 8'h00, 1);
      chk("seq_req", {mem_req, pc}, {1'b1, 8'(i)});
      tick();
      drive(0, 0, 0, 0, 0, 8'h00, 1);
      chk("seq_count", pc_count, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    chk("seq_pc4", pc, 8'h04);
    tick();
    drive(0, 0, 0, 0, 0, 8'h80, 0);
    tick();

    // Jump at pc=4 (previous drive was a no-jump decode -> undo: now in FETCH at 5)
    drive(0, 0, 0, 0, 0, 8'h00, 1); tick();
    drive(0, 0, 0, 0, 1, 8'h80, 0);
    chk("jump_ctl", {pc_load, pc_count, pc_load_value}, {1'b1, 1'b0, 8'h80});
    tick();
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    chk("jump_pc", pc, 8'h80);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 8'h05, 0);
      chk("stall_hold", {pc_enable, instr_valid, pc}, {1'b0, 1'b1, 8'h80});
      tick();
    end
    drive(0, 0, 0, 0, 1, 8'h05, 0);
    chk("stall_jump", {pc_load, pc_count}, 2'b10);
    tick();

    // Memory wait at pc=5
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 8'h00, 0);
      chk("wait", {mem_req, instr_valid, pc}, {1'b1, 1'b0, 8'h05});
      tick();
    end
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    chk("wait_hs", mem_req, 1);
    tick();
    drive(0, 0, 0, 0, 1, 8'h09, 0);
    chk("wait_dec", {instr_valid, instr}, {1'b1, mem[5]});
    tick();

    // Halt / resume at pc=9
    drive(0, 0, 0, 0, 0, 8'h00, 1); tick();
    drive(0, 1, 1, 0, 0, 8'h00, 0);
    chk("halt_en", pc_enable, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      chk("halted", {halted, running, pc}, {1'b1, 1'b0, 8'h09});
      tick();
    end
    drive(0, 1, 0, 0, 0, 8'h00, 0); tick();
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    chk("resume", {mem_req, running, pc}, {1'b1, 1'b1, 8'h09});
    tick();

    // Wrap
    drive(0, 0, 0, 0, 1, 8'hFF, 0); tick();
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    chk("pc_ff", pc, 8'hFF);
    tick();
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    chk("wrap", {wrap, pc_count}, 2'b11);
    tick();
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    chk("wrap_pc", {wrap, mem_req, pc}, {1'b0, 1'b1, 8'h00});
    tick();

    // Reset mid-fetch
    drive(0, 0, 0, 0, 1, 8'h40, 1); tick();
    drive(0, 0, 0, 0, 1, 8'h40, 0); tick();
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    chk("rst_fetch", {mem_req, pc}, {1'b1, 8'h40});
    tick();
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    chk("rst_after", {mem_req, running, halted, instr_valid, instr, pc}, 40'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) == 0), ($urandom_range(3) == 0), 8'($urandom),
            ($urandom_range(2) != 0));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
